// File: rtl/kernel_cc_ctrl_pkg.sv
// kernel_cc_ctrl_pkg: shared types and constants for kernel_cc start-token control.
// No ports; imported by the interface, counter and reader top.
package kernel_cc_ctrl_pkg;

    localparam int INFLIGHT_W = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_START = 1'b1
    } start_state_t;

endpackage

// File: rtl/kernel_cc_start_token_reader_if.sv
// kernel_cc_start_token_reader_if: FIFO read port, process control port and
// parent completion port of the start-token reader.
//  FIFO    : fifo_empty_n, fifo_dout (to reader), fifo_read (from reader)
//  Process : proc_ap_ready, proc_ap_done (to reader), proc_ap_start, proc_ap_continue
//  Parent  : done_ack (to reader), done_valid, token_q, inflight, iter_count
//  slave = reader side, master = environment side.
interface kernel_cc_start_token_reader_if #(
    parameter int DATA_WIDTH = 1,
    parameter int CNT_WIDTH  = 32
);
    import kernel_cc_ctrl_pkg::*;

    logic                  fifo_empty_n;
    logic                  fifo_read;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  proc_ap_start;
    logic                  proc_ap_ready;
    logic                  proc_ap_done;
    logic                  proc_ap_continue;
    logic [DATA_WIDTH-1:0] token_q;
    logic                  done_valid;
    logic                  done_ack;
    logic [INFLIGHT_W-1:0] inflight;
    logic [CNT_WIDTH-1:0]  iter_count;

    modport slave (
        input  fifo_empty_n, fifo_dout, proc_ap_ready, proc_ap_done, done_ack,
        output fifo_read, proc_ap_start, proc_ap_continue,
        output token_q, done_valid, inflight, iter_count
    );

    modport master (
        output fifo_empty_n, fifo_dout, proc_ap_ready, proc_ap_done, done_ack,
        input  fifo_read, proc_ap_start, proc_ap_continue,
        input  token_q, done_valid, inflight, iter_count
    );

endinterface

// File: rtl/kernel_cc_inflight_cnt.sv
// kernel_cc_inflight_cnt: up/down count of started-but-not-continued iterations.
// Ports: clk, reset (sync, active-high), inc_i, dec_i, count_o, at_max_o.
module kernel_cc_inflight_cnt
    import kernel_cc_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_i,
    input  logic                  dec_i,
    output logic [INFLIGHT_W-1:0] count_o,
    output logic                  at_max_o
);

    localparam logic [INFLIGHT_W-1:0] MAX_C = INFLIGHT_W'(MAX_INFLIGHT);

    logic [INFLIGHT_W-1:0] count_q;
    logic [INFLIGHT_W-1:0] count_d;

    // Simultaneous inc and dec cancel out.
    always_comb begin
        count_d = count_q;
        unique case (1'b1)
            inc_i & ~dec_i: count_d = count_q + INFLIGHT_W'(1);
            dec_i & ~inc_i: count_d = count_q - INFLIGHT_W'(1);
            default:        count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign at_max_o = (count_q == MAX_C);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(inc_i && !dec_i && at_max_o))
                else $error("inflight counter overflow");
            assert (!(dec_i && !inc_i && count_q == '0))
                else $error("inflight counter underflow");
        end
    end
`endif

endmodule

// File: rtl/kernel_cc_start_token_reader.sv
// kernel_cc_start_token_reader: pops start tokens and drives ap_start/ap_continue
// of a downstream process. Ports: clk, reset (sync, active-high), bus (slave).
module kernel_cc_start_token_reader
    import kernel_cc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 1,
    parameter int MAX_INFLIGHT = 2,
    parameter int CNT_WIDTH    = 32
) (
    input logic                           clk,
    input logic                           reset,
    kernel_cc_start_token_reader_if.slave bus
);

    localparam int NW = INFLIGHT_W + 1;
    localparam logic [NW-1:0] MAX_W = NW'(MAX_INFLIGHT);

    start_state_t          state_q;
    start_state_t          state_d;
    logic [DATA_WIDTH-1:0] token_q;
    logic [DATA_WIDTH-1:0] token_d;
    logic [CNT_WIDTH-1:0]  iter_q;
    logic [CNT_WIDTH-1:0]  iter_d;

    logic [INFLIGHT_W-1:0] inflight;
    logic                  at_max;
    logic                  done_valid;
    logic                  cont;
    logic                  accept;
    logic                  idle_pop;
    logic                  re_pop;
    logic                  pop;
    logic [NW-1:0]         net_cnt;

    // All combinational strobes are suppressed in the reset cycle so no
    // token is popped and no done is released while state is discarded.
    assign done_valid = ~reset & bus.proc_ap_done & (inflight != '0);
    assign cont       = done_valid & bus.done_ack;
    assign accept     = ~reset & (state_q == S_START) & bus.proc_ap_ready;

    // Count after this cycle's continue, before any start is counted.
    assign net_cnt = {1'b0, inflight} - NW'(cont);

    // at_max with no continue is exactly net_cnt >= MAX.
    assign idle_pop = (state_q == S_IDLE) & bus.fifo_empty_n
                    & (~at_max | cont);
    assign re_pop   = accept & bus.fifo_empty_n
                    & ((net_cnt + NW'(1)) < MAX_W);
    assign pop      = ~reset & (idle_pop | re_pop);

    always_comb begin
        state_d = state_q;
        token_d = token_q;
        iter_d  = iter_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) state_d = S_START;
            end
            S_START: begin
                if (accept && !re_pop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (pop)  token_d = bus.fifo_dout;
        if (cont) iter_d  = iter_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            token_q <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            token_q <= token_d;
            iter_q  <= iter_d;
        end
    end

    kernel_cc_inflight_cnt #(
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (accept),
        .dec_i   (cont),
        .count_o (inflight),
        .at_max_o(at_max)
    );

    assign bus.fifo_read        = pop;
    assign bus.proc_ap_start    = (state_q == S_START);
    assign bus.proc_ap_continue = cont;
    assign bus.token_q          = token_q;
    assign bus.done_valid       = done_valid;
    assign bus.inflight         = inflight;
    assign bus.iter_count       = iter_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && bus.proc_ap_done) begin
            assert (inflight != '0)
                else $error("ap_done with no iteration in flight");
        end
    end
`endif

endmodule

// File: tb/tb_kernel_cc_start_token_reader.sv
// Bench for kernel_cc_start_token_reader: directed vectors plus a
// scoreboard of popped tokens checked when each start is accepted.
module tb_kernel_cc_start_token_reader;

    localparam int DW   = 1;
    localparam int MAXI = 2;
    localparam int CW   = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    kernel_cc_start_token_reader_if #(
        .DATA_WIDTH(DW), .CNT_WIDTH(CW)
    ) bus ();

    kernel_cc_start_token_reader #(
        .DATA_WIDTH(DW), .MAX_INFLIGHT(MAXI), .CNT_WIDTH(CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_tok[$];
    logic          pop_pend   = 1'b0;
    logic          last_cont  = 1'b0;
    logic          prev_start = 1'b0;
    logic          prev_ready = 1'b0;
    logic          prev_reset = 1'b1;
    int            n_pops = 0;
    int            n_acc  = 0;
    int            n_cont = 0;
    int            m_infl = 0;
    logic [CW-1:0] m_iter = '0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void refresh();
        bus.fifo_empty_n = (fq.size() != 0);
        bus.fifo_dout    = (fq.size() != 0) ? fq[0] : '0;
    endfunction

    task automatic push(input logic [DW-1:0] v);
        fq.push_back(v);
        refresh();
    endtask

    // Advance one cycle; the FIFO model retires the pop seen at the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (pop_pend) begin
            chk("pop_nonempty", fq.size() != 0, 1);
            if (fq.size() != 0) begin
                exp_tok.push_back(fq.pop_front());
                n_pops++;
            end
        end
        refresh();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((fq.size() != 0 || m_infl != 0 || bus.proc_ap_start)
               && n < 200) begin
            bus.proc_ap_ready = 1'b1;
            bus.proc_ap_done  = (m_infl != 0);
            bus.done_ack      = 1'b1;
            cyc();
            n++;
        end
        bus.proc_ap_ready = 1'b0;
        bus.proc_ap_done  = 1'b0;
        bus.done_ack      = 1'b0;
        chk("drain_in_budget", n < 200, 1);
    endtask

    // Monitor: per-cycle protocol checks and start-token scoreboard.
    always @(negedge clk) begin
        logic acc;
        logic cont;
        logic dv;
        acc  = bus.proc_ap_start & bus.proc_ap_ready & ~reset;
        cont = bus.proc_ap_continue;
        dv   = ~reset & bus.proc_ap_done & (m_infl != 0);
        chk("inflight", bus.inflight, m_infl);
        chk("iter_count", bus.iter_count, m_iter);
        chk("done_valid", bus.done_valid, dv);
        chk("continue", cont, dv & bus.done_ack);
        if (reset) chk("reset_no_pop", bus.fifo_read, 0);
        if (prev_start & ~prev_ready & ~prev_reset)
            chk("start_hold", bus.proc_ap_start, 1);
        if (bus.fifo_read)
            chk("pop_credit", (m_infl + int'(acc) - int'(cont)) < MAXI, 1);
        if (acc) begin
            n_acc++;
            chk("tok_queue_depth", exp_tok.size(), 1);
            if (exp_tok.size() != 0)
                chk("start_token", bus.token_q, exp_tok.pop_front());
        end
        if (reset) begin
            m_infl = 0;
            m_iter = '0;
            exp_tok.delete();
        end else begin
            m_infl = m_infl + int'(acc) - int'(cont);
            m_iter = m_iter + CW'(cont);
        end
        n_cont     = n_cont + int'(cont);
        last_cont  = cont;
        pop_pend   = bus.fifo_read;
        prev_start = bus.proc_ap_start;
        prev_ready = bus.proc_ap_ready;
        prev_reset = reset;
    end

    initial begin
        int p0;
        int a0;
        int c0;
        int sz;
        logic [CW-1:0] i0;

        reset             = 1'b1;
        bus.fifo_empty_n  = 1'b0;
        bus.fifo_dout     = '0;
        bus.proc_ap_ready = 1'b0;
        bus.proc_ap_done  = 1'b0;
        bus.done_ack      = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_fifo_read", bus.fifo_read, 0);
        chk("rst_ap_start", bus.proc_ap_start, 0);
        chk("rst_continue", bus.proc_ap_continue, 0);
        chk("rst_done_valid", bus.done_valid, 0);
        chk("rst_token", bus.token_q, 0);
        chk("rst_inflight", bus.inflight, 0);
        chk("rst_iter", bus.iter_count, 0);

        // 1: single token, ready three cycles after the push.
        cyc();
        reset = 1'b0;
        push(1'b1);
        @(negedge clk);
        chk("t1_pop", bus.fifo_read, 1);
        chk("t1_start_lo", bus.proc_ap_start, 0);
        cyc();
        @(negedge clk);
        chk("t1_pop_once", bus.fifo_read, 0);
        chk("t1_start_hi", bus.proc_ap_start, 1);
        cyc();
        @(negedge clk);
        chk("t1_start_held", bus.proc_ap_start, 1);
        cyc();
        bus.proc_ap_ready = 1'b1;
        @(negedge clk);
        chk("t1_start_at_ready", bus.proc_ap_start, 1);
        cyc();
        bus.proc_ap_ready = 1'b0;
        @(negedge clk);
        chk("t1_inflight", bus.inflight, 1);
        chk("t1_token", bus.token_q, 1);
        chk("t1_start_drop", bus.proc_ap_start, 0);

        // 2: four tokens, ready tied high, credit limit of two.
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        p0 = n_pops;
        bus.proc_ap_ready = 1'b1;
        push(1'b0);
        push(1'b1);
        push(1'b1);
        push(1'b0);
        repeat (5) cyc();
        @(negedge clk);
        chk("t2_start_lo", bus.proc_ap_start, 0);
        chk("t2_no_pop", bus.fifo_read, 0);
        chk("t2_inflight", bus.inflight, 2);
        chk("t2_fifo_left", fq.size(), 2);
        chk("t2_pops", n_pops - p0, 2);

        // 3: continue frees credit; ready and continue together net zero.
        cyc();
        bus.proc_ap_done = 1'b1;
        bus.done_ack     = 1'b1;
        @(negedge clk);
        chk("t3_third_pop", bus.fifo_read, 1);
        chk("t3_cont", bus.proc_ap_continue, 1);
        cyc();
        @(negedge clk);
        chk("t3_inflight_a", bus.inflight, 1);
        chk("t3_iter_a", bus.iter_count, 1);
        chk("t3_start", bus.proc_ap_start, 1);
        chk("t3_cont_b", bus.proc_ap_continue, 1);
        chk("t3_net_repop", bus.fifo_read, 1);
        cyc();
        bus.proc_ap_done = 1'b0;
        bus.done_ack     = 1'b0;
        @(negedge clk);
        chk("t3_inflight_net0", bus.inflight, 1);
        chk("t3_iter_b", bus.iter_count, 2);
        chk("t3_empty_no_pop", bus.fifo_read, 0);
        cyc();
        @(negedge clk);
        chk("t3_inflight_c", bus.inflight, 2);
        chk("t3_idle", bus.proc_ap_start, 0);
        chk("t3_fifo_empty", fq.size(), 0);

        // 4: done held without ack, then a single acknowledged continue.
        cyc();
        bus.proc_ap_ready = 1'b0;
        bus.proc_ap_done  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_dv_held", bus.done_valid, 1);
            chk("t4_cont_lo", bus.proc_ap_continue, 0);
            cyc();
        end
        bus.done_ack = 1'b1;
        @(negedge clk);
        chk("t4_cont_hi", bus.proc_ap_continue, 1);
        chk("t4_iter_pre", bus.iter_count, 2);
        cyc();
        bus.proc_ap_done = 1'b0;
        bus.done_ack     = 1'b0;
        @(negedge clk);
        chk("t4_cont_pulse", bus.proc_ap_continue, 0);
        chk("t4_iter", bus.iter_count, 3);
        chk("t4_inflight", bus.inflight, 1);

        // 5: reset while ap_start is high and a pop is tempting.
        cyc();
        push(1'b1);
        @(negedge clk);
        chk("t5_pop", bus.fifo_read, 1);
        cyc();
        @(negedge clk);
        chk("t5_start", bus.proc_ap_start, 1);
        cyc();
        reset             = 1'b1;
        bus.proc_ap_ready = 1'b1;
        push(1'b0);
        sz = fq.size();
        @(negedge clk);
        chk("t5_rst_no_pop", bus.fifo_read, 0);
        cyc();
        @(negedge clk);
        chk("t5_start_lo", bus.proc_ap_start, 0);
        chk("t5_fifo_read", bus.fifo_read, 0);
        chk("t5_cont", bus.proc_ap_continue, 0);
        chk("t5_dv", bus.done_valid, 0);
        chk("t5_inflight", bus.inflight, 0);
        chk("t5_iter", bus.iter_count, 0);
        chk("t5_token", bus.token_q, 0);
        chk("t5_fifo_count", fq.size(), sz);
        cyc();
        reset = 1'b0;
        drain();

        // 6: random stress.
        p0 = n_pops;
        a0 = n_acc;
        c0 = n_cont;
        i0 = m_iter;
        for (int i = 0; i < 10000; i++) begin
            if (fq.size() < 3 && $urandom_range(0, 2) == 0)
                push(DW'($urandom_range(0, 1)));
            bus.proc_ap_ready = 1'($urandom_range(0, 1));
            if (!bus.proc_ap_done || last_cont)
                bus.proc_ap_done = (m_infl != 0)
                                 && ($urandom_range(0, 2) == 0);
            bus.done_ack = 1'($urandom_range(0, 1));
            cyc();
        end
        drain();
        @(negedge clk);
        chk("t6_pops_eq_starts", n_pops - p0, n_acc - a0);
        chk("t6_iter_eq_cont", bus.iter_count, i0 + CW'(n_cont - c0));
        chk("t6_tok_queue_empty", exp_tok.size(), 0);
        chk("t6_inflight_zero", bus.inflight, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
